// File: rtl/fifo_ms_pkg.sv
// Shared types and elaboration helpers for the multi-stream FIFO and its arbiter.
package fifo_ms_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   // Width helper that never returns zero, so single-entry dimensions still get one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
   endfunction

   function automatic int wrap_inc(input int ptr, input int depth);
      return (ptr >= depth - 32'sd1) ? 32'sd0 : ptr + 32'sd1;
   endfunction

endpackage

// File: rtl/ms_arbiter.sv
// One-of-FLUX grant selector: fixed priority (highest index) or round robin with a registered pointer.
module ms_arbiter
   import fifo_ms_pkg::*;
#(
   parameter int FLUX     = 2,
   parameter int ARB_MODE = 0,
   parameter int IW       = clog2_min1(FLUX)
) (
   input  logic            ck,
   input  logic            rst,
   input  logic [FLUX-1:0] req,
   output logic [FLUX-1:0] gnt,
   output logic [IW-1:0]   gnt_idx,
   output logic            gnt_any
);

   logic [IW-1:0] rr_ptr_r;
   logic [IW-1:0] fix_idx_s;
   logic [IW-1:0] low_idx_s;
   logic [IW-1:0] hi_idx_s;
   logic          hi_any_s;

   // Candidate search: highest requester for fixed mode; for round robin the lowest requester at or above the pointer, else the lowest overall
   always_comb begin
      fix_idx_s = '0;
      low_idx_s = '0;
      hi_idx_s  = '0;
      hi_any_s  = 1'b0;
      for (int j = 0; j < FLUX; j++) begin
         fix_idx_s = req[j] ? IW'(j) : fix_idx_s;
      end
      for (int j = FLUX - 1; j >= 0; j--) begin
         low_idx_s = req[j] ? IW'(j) : low_idx_s;
         hi_idx_s  = (req[j] && (j >= int'(rr_ptr_r))) ? IW'(j) : hi_idx_s;
         hi_any_s  = hi_any_s | (req[j] && (j >= int'(rr_ptr_r)));
      end
   end

   assign gnt_any = |req;
   assign gnt_idx = (ARB_MODE == int'(ARB_RR)) ? (hi_any_s ? hi_idx_s : low_idx_s) : fix_idx_s;
   assign gnt     = gnt_any ? (FLUX'(1'b1) << gnt_idx) : '0;

   // Round-robin pointer moves just past each granted stream and holds when idle
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         rr_ptr_r <= '0;
      end else if (gnt_any) begin
         rr_ptr_r <= IW'(wrap_inc(int'(gnt_idx), FLUX));
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

endmodule

// File: rtl/fifo_ms_arb.sv
// Multi-stream FIFO: tagged writes fan into FLUX circular queues; one arbitrated pop per cycle
// drives a registered output with valid and tag.
module fifo_ms_arb
   import fifo_ms_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int FLUX      = 2,
   parameter int TAG_WIDTH = $clog2(FLUX),
   parameter int ARB_MODE  = 0,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int CNT_WIDTH = 16
) (
   input  logic                              ck,
   input  logic                              rst,
   input  logic                              wr,
   input  logic [WIDTH-1:0]                  datain,
   input  logic [FLUX-1:0]                   rd,
   output logic [FLUX-1:0]                   full,
   output logic [FLUX-1:0]                   empty,
   output logic [FLUX-1:0]                   almost_full,
   output logic [FLUX*$clog2(DEPTH+1)-1:0]   level,
   output logic [WIDTH-1:0]                  dataout,
   output logic                              dout_valid,
   output logic [TAG_WIDTH-1:0]              dout_tag,
   output logic [CNT_WIDTH-1:0]              drop_cnt
);

   localparam int PW = clog2_min1(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [TAG_WIDTH-1:0] tag_s;
   logic                 tag_ok_s;
   logic                 acc_s;
   logic                 drop_s;
   logic [FLUX-1:0]      full_s;
   logic [FLUX-1:0]      empty_s;
   logic [FLUX-1:0]      elig_s;
   logic [FLUX-1:0]      gnt_s;
   logic [TAG_WIDTH-1:0] gnt_idx_s;
   logic                 gnt_any_s;
   logic [WIDTH-1:0]     head_s [FLUX];

   assign tag_s    = datain[WIDTH-1 -: TAG_WIDTH];
   assign tag_ok_s = (int'(tag_s) < FLUX);
   // A full stream rejects even when it pops in the same cycle; there is no write-through.
   assign acc_s    = wr && tag_ok_s && !full_s[tag_s];
   assign drop_s   = wr && !acc_s;
   assign elig_s   = rd & ~empty_s;

   assign full  = full_s;
   assign empty = empty_s;

   ms_arbiter #(
      .FLUX     (FLUX),
      .ARB_MODE (ARB_MODE),
      .IW       (TAG_WIDTH)
   ) u_arb (
      .ck      (ck),
      .rst     (rst),
      .req     (elig_s),
      .gnt     (gnt_s),
      .gnt_idx (gnt_idx_s),
      .gnt_any (gnt_any_s)
   );

   for (genvar i = 0; i < FLUX; i++) begin : g_q
      logic [WIDTH-1:0] mem_r [DEPTH];
      logic [PW-1:0]    wp_r;
      logic [PW-1:0]    rp_r;
      logic [LW-1:0]    lvl_r;
      logic             wr_s;
      logic             pop_s;

      assign wr_s  = acc_s && (tag_s == TAG_WIDTH'(i));
      assign pop_s = gnt_s[i];

      assign full_s[i]            = (lvl_r == LW'(DEPTH));
      assign empty_s[i]           = (lvl_r == '0);
      assign almost_full[i]       = (lvl_r >= LW'(AF_THRESH));
      assign level[i*LW +: LW]    = lvl_r;
      assign head_s[i]            = mem_r[rp_r];

      // Storage is deliberately left out of reset
      always_ff @(posedge ck) begin
         if (wr_s) begin
            mem_r[wp_r] <= datain;
         end
      end

      // Pointers wrap at DEPTH-1; level nets accepted write against pop
      always_ff @(posedge ck or negedge rst) begin
         if (!rst) begin
            wp_r  <= '0;
            rp_r  <= '0;
            lvl_r <= '0;
         end else begin
            wp_r  <= wr_s  ? PW'(wrap_inc(int'(wp_r), DEPTH)) : wp_r;
            rp_r  <= pop_s ? PW'(wrap_inc(int'(rp_r), DEPTH)) : rp_r;
            lvl_r <= lvl_r + LW'(wr_s) - LW'(pop_s);
         end
      end
   end

   // Output register: captures the granted head word; data and tag hold when idle
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         dataout    <= '0;
         dout_tag   <= '0;
         dout_valid <= 1'b0;
      end else if (gnt_any_s) begin
         dataout    <= head_s[gnt_idx_s];
         dout_tag   <= gnt_idx_s;
         dout_valid <= 1'b1;
      end else begin
         dout_valid <= 1'b0;
      end
   end

   // Saturating count of rejected writes
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         drop_cnt <= '0;
      end else if (drop_s && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + CNT_WIDTH'(1'b1);
      end else begin
         drop_cnt <= drop_cnt;
      end
   end

endmodule

// File: tb/tb_fifo_ms_arb.sv
// Directed bench: a round-robin instance carries most traffic, a fixed-priority instance
// shows the priority order; expected pops are queued and matched on every clock.
module tb_fifo_ms_arb;

   logic       ck = 1'b0;
   logic       rst;
   logic       wr_a, wr_b;
   logic [7:0] din_a, din_b;
   logic [3:0] rd_a, rd_b;

   logic [3:0]  full_a, empty_a, af_a, full_b, empty_b, af_b;
   logic [7:0]  level_a, level_b, dout_a, dout_b;
   logic        dv_a, dv_b;
   logic [1:0]  dtag_a, dtag_b;
   logic [15:0] drop_a, drop_b;

   typedef struct packed {
      logic [1:0] tag;
      logic [7:0] data;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   tests = 0;
   int   fails = 0;

   always #5 ck = ~ck;

   fifo_ms_arb #(.WIDTH(8), .DEPTH(3), .FLUX(4), .ARB_MODE(1)) dut_rr (
      .ck(ck), .rst(rst), .wr(wr_a), .datain(din_a), .rd(rd_a),
      .full(full_a), .empty(empty_a), .almost_full(af_a), .level(level_a),
      .dataout(dout_a), .dout_valid(dv_a), .dout_tag(dtag_a), .drop_cnt(drop_a)
   );

   fifo_ms_arb #(.WIDTH(8), .DEPTH(3), .FLUX(4), .ARB_MODE(0)) dut_fp (
      .ck(ck), .rst(rst), .wr(wr_b), .datain(din_b), .rd(rd_b),
      .full(full_b), .empty(empty_b), .almost_full(af_b), .level(level_b),
      .dataout(dout_b), .dout_valid(dv_b), .dout_tag(dtag_b), .drop_cnt(drop_b)
   );

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
      end
   endtask

   // Advance one clock, then every cycle either consume one queued pop or require an idle output.
   task automatic tick();
      exp_t e;
      @(posedge ck);
      #1;
      if (q_a.size() > 0) begin
         e = q_a.pop_front();
         chk("rr_valid", 32'(dv_a), 32'd1);
         chk("rr_data", 32'(dout_a), 32'(e.data));
         chk("rr_tag", 32'(dtag_a), 32'(e.tag));
      end else begin
         chk("rr_idle", 32'(dv_a), 32'd0);
      end
      if (q_b.size() > 0) begin
         e = q_b.pop_front();
         chk("fp_valid", 32'(dv_b), 32'd1);
         chk("fp_data", 32'(dout_b), 32'(e.data));
         chk("fp_tag", 32'(dtag_b), 32'(e.tag));
      end else begin
         chk("fp_idle", 32'(dv_b), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of sequence");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; wr_a = 1'b0; wr_b = 1'b0; din_a = 8'h00; din_b = 8'h00; rd_a = 4'h0; rd_b = 4'h0;
      tick();
      tick();
      chk("rst_empty", 32'(empty_a), 32'h0000000F);
      chk("rst_full", 32'(full_a), 32'h0);
      chk("rst_af", 32'(af_a), 32'h0);
      chk("rst_level", 32'(level_a), 32'h0);
      chk("rst_dataout", 32'(dout_a), 32'h0);
      chk("rst_tag", 32'(dtag_a), 32'h0);
      chk("rst_drop", 32'(drop_a), 32'h0);
      rst = 1'b1;

      // Fill stream 0 to full and put one word in stream 1
      wr_a = 1'b1;
      din_a = 8'h01; tick();
      din_a = 8'h02; tick();
      din_a = 8'h03; tick();
      din_a = 8'h41; tick();
      wr_a = 1'b0;
      chk("fill_level0", 32'(level_a[1:0]), 32'd3);
      chk("fill_level1", 32'(level_a[3:2]), 32'd1);
      chk("fill_full", 32'(full_a), 32'b0001);
      chk("fill_empty", 32'(empty_a), 32'b1100);
      chk("fill_af", 32'(af_a), 32'b0001);

      // Write to a full stream while it pops: write is dropped, head word comes out
      wr_a = 1'b1; din_a = 8'h04; rd_a = 4'b0001;
      q_a.push_back({2'd0, 8'h01});
      tick();
      wr_a = 1'b0; rd_a = 4'b0000;
      chk("drop_cnt1", 32'(drop_a), 32'd1);
      chk("drop_level0", 32'(level_a[1:0]), 32'd2);

      // Round robin across streams 0 and 1 (pointer sits at 1 after the stream 0 grant)
      rd_a = 4'b0011;
      q_a.push_back({2'd1, 8'h41});
      q_a.push_back({2'd0, 8'h02});
      q_a.push_back({2'd0, 8'h03});
      tick(); tick(); tick(); tick();
      rd_a = 4'b0000;
      chk("rr_drained", 32'(empty_a), 32'hF);

      // Fixed priority: stream 1 drains fully before stream 0
      wr_b = 1'b1;
      din_b = 8'h01; tick();
      din_b = 8'h02; tick();
      din_b = 8'h41; tick();
      din_b = 8'h42; tick();
      wr_b = 1'b0;
      rd_b = 4'b0011;
      q_b.push_back({2'd1, 8'h41});
      q_b.push_back({2'd1, 8'h42});
      q_b.push_back({2'd0, 8'h01});
      q_b.push_back({2'd0, 8'h02});
      tick(); tick(); tick(); tick(); tick();
      rd_b = 4'b0000;
      chk("fp_drained", 32'(empty_b), 32'hF);
      chk("fp_drop", 32'(drop_b), 32'd0);

      // No bypass: a word written this cycle cannot pop until the next
      wr_a = 1'b1; din_a = 8'h81; rd_a = 4'b0100;
      tick();
      wr_a = 1'b0;
      chk("nobypass_level2", 32'(level_a[5:4]), 32'd1);
      q_a.push_back({2'd2, 8'h81});
      tick();
      rd_a = 4'b0000;

      // Wrap check on stream 3: ten write/pop pairs through a depth-3 queue
      wr_a = 1'b1; din_a = 8'hC0;
      tick();
      chk("wrap_level_first", 32'(level_a[7:6]), 32'd1);
      for (int k = 1; k < 10; k++) begin
         din_a = 8'hC0 + 8'(k);
         rd_a = 4'b1000;
         q_a.push_back({2'd3, 8'hC0 + 8'(k - 1)});
         tick();
         chk("wrap_level", 32'(level_a[7:6]), 32'd1);
      end
      wr_a = 1'b0;
      q_a.push_back({2'd3, 8'hC9});
      tick();
      rd_a = 4'b0000;
      chk("wrap_level_last", 32'(level_a[7:6]), 32'd0);

      // Queue data, pop once so the output is valid, then reset asynchronously mid-cycle
      wr_a = 1'b1; din_a = 8'h05;
      tick();
      din_a = 8'h06; rd_a = 4'b0001;
      q_a.push_back({2'd0, 8'h05});
      tick();
      wr_a = 1'b0; rd_a = 4'b0000;
      #2 rst = 1'b0;
      #1;
      chk("arst_valid", 32'(dv_a), 32'd0);
      chk("arst_empty", 32'(empty_a), 32'b1111);
      chk("arst_drop", 32'(drop_a), 32'd0);
      chk("arst_level", 32'(level_a), 32'd0);
      tick();
      rst = 1'b1;

      // After reset release the first accepted write is the first word read
      wr_a = 1'b1; din_a = 8'h07;
      tick();
      wr_a = 1'b0; rd_a = 4'b0001;
      q_a.push_back({2'd0, 8'h07});
      tick();
      rd_a = 4'b0000;
      tick();
      chk("end_empty", 32'(empty_a), 32'hF);
      chk("end_queue_rr", 32'(q_a.size()), 32'd0);
      chk("end_queue_fp", 32'(q_b.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo_ms_arb.md
Name: fifo_ms_arb

Overview:
Multi-stream FIFO: one tagged write port fans into FLUX independent circular queues; per-stream read requests are arbitrated so that at most one queue pops per cycle onto a single registered output. Successor to the fixed-priority multi-stream pick FIFO, adding:
- arbitrary (non power-of-two) DEPTH;
- selectable fixed-priority or round-robin arbitration;
- occupancy levels, almost-full flags, a valid-qualified output and a drop counter.

Parameters:
WIDTH, 8, datain/dataout width in bits including tag field
DEPTH, 4, entries per stream, any value >= 2
FLUX, 2, number of streams, >= 2
TAG_WIDTH, $clog2(FLUX), tag field width; tag = datain[WIDTH-1 -: TAG_WIDTH]
ARB_MODE, 0, 0 = fixed priority (highest index wins), 1 = round robin
AF_THRESH, DEPTH-1, almost_full asserts when level >= AF_THRESH
CNT_WIDTH, 16, drop counter width

Ports:
ck  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
wr  in  1  write strobe
datain  in  WIDTH  write data; top TAG_WIDTH bits select the stream
rd  in  FLUX  per-stream read request
full  out  FLUX  stream i holds DEPTH entries
empty  out  FLUX  stream i holds 0 entries
almost_full  out  FLUX  level[i] >= AF_THRESH
level  out  FLUX*$clog2(DEPTH+1)  packed occupancy, stream i at slice i
dataout  out  WIDTH  popped word, registered
dout_valid  out  1  dataout carries a word popped in the previous cycle
dout_tag  out  TAG_WIDTH  stream index of dataout
drop_cnt  out  CNT_WIDTH  saturating count of rejected writes

Behaviour:
- Reset (rst low, asynchronous):
  - all pointers, levels and drop_cnt = 0; RR pointer = 0;
  - dataout = 0, dout_valid = 0, dout_tag = 0;
  - empty = all 1, full = 0, almost_full = 0.
  - Memory contents are not reset.
- Write:
  - Accepted when wr=1, tag < FLUX and full[tag]=0.
  - On acceptance: mem[tag][wp[tag]] <= datain; wp wraps from DEPTH-1 to 0.
- Drop:
  - A write is dropped when tag >= FLUX or the stream is full.
  - A full stream rejects the write even if the same stream pops that cycle; no write-through.
  - Each drop increments drop_cnt by 1, saturating at all-ones.
- Eligibility: elig = rd & ~empty, using registered state only. A word written in cycle N becomes poppable in cycle N+1; no bypass.
- Arbitration:
  - ARB_MODE 0: grant the highest-index eligible stream.
  - ARB_MODE 1: grant the first eligible stream at or after rr_ptr, searching upward with wrap; after a grant, rr_ptr <= grant+1 mod FLUX. rr_ptr is unchanged when there is no grant.
- Pop: the granted stream reads mem[g][rp[g]]; rp wraps at DEPTH-1.
- Output timing, 1-cycle latency:
  - Grant in cycle N gives dataout/dout_tag/dout_valid=1 at edge N+1.
  - With no grant, dout_valid <= 0 and dataout/dout_tag hold their previous values.
- Requests on empty streams or non-granted streams have no effect; their data stays queued.
- Level update per stream per cycle: level += accepted_write - pop, both of which may be 1 on the same stream. This gives flags:
  - full = (level == DEPTH)
  - empty = (level == 0)
  - flags are combinational from registered level.
- Simultaneous write and pop on one non-full, non-empty stream: level unchanged, both pointers advance.
- Reset asserted mid-burst discards all queued data; after release the first accepted write is the first word read.

Decomposition:
- Package fifo_ms_pkg holds:
  - arb_mode_e (ARB_FIXED=0, ARB_RR=1);
  - function clog2_min1 for widths when DEPTH or FLUX = 1;
  - function wrap_inc(ptr, DEPTH).
- One sub-module, ms_arbiter: FLUX-wide request in, one-hot grant plus binary index out, and the RR pointer register. It is instantiated once.
- Queue storage and pointers are generate-looped in the top level.

Test Plan:
- Setup: WIDTH=8, DEPTH=3, FLUX=4, ARB_MODE=1. Reset, then write 0x01,0x02,0x03 to stream 0 and 0x41 to stream 1 -> level0=3, full[0]=1, empty[1]=0, empty[2]=empty[3]=1.
- Fourth write 0x04 to full stream 0 while rd[0]=1 in the same cycle -> write dropped, drop_cnt=1, next cycle dataout=0x01, dout_tag=0, level0=2.
- rd=4'b0011 held for 4 cycles with RR -> dataout sequence 0x41(tag1), 0x02(tag0), 0x03(tag0), then dout_valid=0.
- Same traffic with ARB_MODE=0 -> stream 1 drains fully before stream 0.
- Write 0x81 to empty stream 2 with rd[2]=1 in the same cycle -> no pop that cycle, dout_valid=0; a pop the following cycle gives dataout=0x81.
- Wrap check: 10 write/pop pairs on stream 3 with DEPTH=3 -> data in order, level never exceeds 1. Then assert rst low mid-run -> asynchronous clear of dout_valid, empty=4'b1111, drop_cnt=0.
